// File: rtl/bellek_arabirimi_pkg.sv
// Shared constants, types and state encoding for the line-organised RAM front-end.
// Contents:
//   ADRES_BIT, VO_VERI_BIT  address and line widths
//   SATIR_OFSET_BIT         bit-offset width inside one 128-bit line
//   SATIR_ALAN_BIT          width of the line-index field of an address
//   durum_e                 controller states
//   istek_t                 one buffered multiplier request (kind, address, data)
package bellek_arabirimi_pkg;

  localparam int ADRES_BIT       = 32;
  localparam int VO_VERI_BIT     = 128;
  localparam int SATIR_OFSET_BIT = 7;
  localparam int SATIR_ALAN_BIT  = ADRES_BIT - SATIR_OFSET_BIT;
  localparam int SAYAC_BIT       = 8;

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    OKU   = 2'd1,
    YAZ   = 2'd2
  } durum_e;

  typedef struct packed {
    logic                   yaz;
    logic [ADRES_BIT-1:0]   adres;
    logic [VO_VERI_BIT-1:0] veri;
  } istek_t;

endpackage

// File: rtl/bellek_arabirimi_bekleyen_istek_kutusu.sv
// One-entry pending-request slot.
// Ports:
//   clk_i, resetn_i  clock, asynchronous active-low reset
//   yukle_i          store istek_i (may coincide with cek_i)
//   cek_i            release the stored request
//   istek_i          request to store
//   dolu_o           slot holds a request
//   istek_o          stored request
module bekleyen_istek_kutusu
  import bellek_arabirimi_pkg::*;
(
  input  logic   clk_i,
  input  logic   resetn_i,
  input  logic   yukle_i,
  input  logic   cek_i,
  input  istek_t istek_i,
  output logic   dolu_o,
  output istek_t istek_o
);

  logic   dolu_q, dolu_d;
  istek_t istek_q, istek_d;

  // A pop and a load on the same edge leave the slot full with the new request.
  always_comb begin
    dolu_d  = dolu_q;
    istek_d = istek_q;
    if (cek_i) begin
      dolu_d = 1'b0;
    end
    if (yukle_i) begin
      dolu_d  = 1'b1;
      istek_d = istek_i;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      dolu_q  <= 1'b0;
      istek_q <= '0;
    end else begin
      dolu_q  <= dolu_d;
      istek_q <= istek_d;
    end
  end

  assign dolu_o  = dolu_q;
  assign istek_o = istek_q;

endmodule

// File: rtl/bellek_arabirimi.sv
// Line-organised RAM front-end serving the matrix multiplier, with a host load path.
// Ports:
//   clk_g, resetn                      clock, asynchronous active-low reset
//   ram_adres_g / ram_oku_gecerli_g /
//   ram_yaz_gecerli_g / ram_yaz_veri_g multiplier request (bit address, read/write pulses, data)
//   ram_oku_veri_c / ram_oku_adres_c /
//   ram_oku_gecerli_c                  returned line, its aligned address, one-cycle valid
//   ram_mesgul_c                       busy (serving or slot full)
//   hata_c                             one-cycle error pulse
//   yukle_gecerli_g / yukle_adres_g /
//   yukle_veri_g                       host line write, honoured only when fully idle
//
// state | meaning
// BOSTA | idle; serves pending slot first, then a new write, then a new read, then host load
// OKU   | read in flight; counter runs down to 0, then the line is returned
// YAZ   | line already written; block stays busy until the counter reaches 0
module bellek_arabirimi
  import bellek_arabirimi_pkg::*;
#(
  parameter int SATIR_SAYISI = 64,
  parameter int OKU_GECIKME  = 3,
  parameter int YAZ_GECIKME  = 2
) (
  input  logic                   clk_g,
  input  logic                   resetn,
  input  logic [ADRES_BIT-1:0]   ram_adres_g,
  input  logic                   ram_oku_gecerli_g,
  input  logic                   ram_yaz_gecerli_g,
  input  logic [VO_VERI_BIT-1:0] ram_yaz_veri_g,
  output logic [VO_VERI_BIT-1:0] ram_oku_veri_c,
  output logic [ADRES_BIT-1:0]   ram_oku_adres_c,
  output logic                   ram_oku_gecerli_c,
  output logic                   ram_mesgul_c,
  output logic                   hata_c,
  input  logic                   yukle_gecerli_g,
  input  logic [ADRES_BIT-1:0]   yukle_adres_g,
  input  logic [VO_VERI_BIT-1:0] yukle_veri_g
);

  localparam int SATIR_BIT = (SATIR_SAYISI > 1) ? $clog2(SATIR_SAYISI) : 1;
  localparam logic [SATIR_ALAN_BIT-1:0] SATIR_SINIR = SATIR_ALAN_BIT'(SATIR_SAYISI);
  localparam logic [SAYAC_BIT-1:0]      OKU_YUKLE   = SAYAC_BIT'(OKU_GECIKME - 1);
  localparam logic [SAYAC_BIT-1:0]      YAZ_YUKLE   = SAYAC_BIT'(YAZ_GECIKME - 1);

  logic [VO_VERI_BIT-1:0] bellek_q [SATIR_SAYISI];

  durum_e                  durum_q, durum_d;
  logic [SAYAC_BIT-1:0]    sayac_q, sayac_d;
  logic [SATIR_ALAN_BIT-1:0] satir_q, satir_d;
  logic [VO_VERI_BIT-1:0]  oku_veri_q, oku_veri_d;
  logic [ADRES_BIT-1:0]    oku_adres_q, oku_adres_d;
  logic                    oku_gecerli_q, oku_gecerli_d;
  logic                    mesgul_q, mesgul_d;
  logic                    hata_q, hata_d;

  istek_t gelen_yaz, gelen_oku, ilk_gelen, kabul, kutu_giris, kutu_cikis;
  logic   kabul_gecerli, kutu_yukle, kutu_cek, kutu_dolu, istek_hata;
  logic   yukle_yaz, yukle_hata, bosta;
  logic   bellek_yaz;
  logic [SATIR_BIT-1:0]      bellek_satir;
  logic [VO_VERI_BIT-1:0]    bellek_veri;
  logic [SATIR_ALAN_BIT-1:0] kabul_satir, yukle_satir;
  logic   unused_ofset;

  assign bosta       = (durum_q == BOSTA);
  assign gelen_yaz   = '{yaz: 1'b1, adres: ram_adres_g, veri: ram_yaz_veri_g};
  assign gelen_oku   = '{yaz: 1'b0, adres: ram_adres_g, veri: '0};
  // When both pulses arrive together the write is taken first.
  assign ilk_gelen   = ram_yaz_gecerli_g ? gelen_yaz : gelen_oku;
  assign kabul_satir = kabul.adres[ADRES_BIT-1:SATIR_OFSET_BIT];
  assign yukle_satir = yukle_adres_g[ADRES_BIT-1:SATIR_OFSET_BIT];
  assign unused_ofset = ^{kabul.adres[SATIR_OFSET_BIT-1:0], yukle_adres_g[SATIR_OFSET_BIT-1:0]};

  bekleyen_istek_kutusu u_kutu (
    .clk_i    (clk_g),
    .resetn_i (resetn),
    .yukle_i  (kutu_yukle),
    .cek_i    (kutu_cek),
    .istek_i  (kutu_giris),
    .dolu_o   (kutu_dolu),
    .istek_o  (kutu_cikis)
  );

  // Request routing: one request can be served directly from BOSTA, one more can be
  // parked in the slot; anything beyond that is dropped with an error pulse.
  always_comb begin
    kabul_gecerli = 1'b0;
    kabul         = '0;
    kutu_yukle    = 1'b0;
    kutu_giris    = '0;
    kutu_cek      = 1'b0;
    istek_hata    = 1'b0;
    yukle_yaz     = 1'b0;
    yukle_hata    = 1'b0;
    if (bosta && !kutu_dolu) begin
      if (ram_yaz_gecerli_g || ram_oku_gecerli_g) begin
        kabul_gecerli = 1'b1;
        kabul         = ilk_gelen;
      end
      if (ram_yaz_gecerli_g && ram_oku_gecerli_g) begin
        kutu_yukle = 1'b1;
        kutu_giris = gelen_oku;
      end
    end else begin
      if (bosta) begin
        kabul_gecerli = 1'b1;
        kabul         = kutu_cikis;
        kutu_cek      = 1'b1;
      end
      if (ram_yaz_gecerli_g || ram_oku_gecerli_g) begin
        // The slot has room if it is empty or is being emptied on this edge.
        if (bosta || !kutu_dolu) begin
          kutu_yukle = 1'b1;
          kutu_giris = ilk_gelen;
          istek_hata = ram_yaz_gecerli_g && ram_oku_gecerli_g;
        end else begin
          istek_hata = 1'b1;
        end
      end
    end
    if (yukle_gecerli_g) begin
      if (bosta && !kutu_dolu && !ram_yaz_gecerli_g && !ram_oku_gecerli_g &&
          (yukle_satir < SATIR_SINIR)) begin
        yukle_yaz = 1'b1;
      end else begin
        yukle_hata = 1'b1;
      end
    end
  end

  always_comb begin
    durum_d = durum_q;
    sayac_d = sayac_q;
    satir_d = satir_q;
    case (durum_q)
      BOSTA: begin
        if (kabul_gecerli) begin
          satir_d = kabul_satir;
          if (kabul.yaz) begin
            durum_d = YAZ;
            sayac_d = YAZ_YUKLE;
          end else begin
            durum_d = OKU;
            sayac_d = OKU_YUKLE;
          end
        end
      end
      OKU, YAZ: begin
        if (sayac_q == '0) begin
          durum_d = BOSTA;
        end else begin
          sayac_d = sayac_q - SAYAC_BIT'(1);
        end
      end
      default: durum_d = BOSTA;
    endcase
  end

  always_comb begin
    oku_gecerli_d = 1'b0;
    oku_veri_d    = oku_veri_q;
    oku_adres_d   = oku_adres_q;
    hata_d        = istek_hata || yukle_hata;
    bellek_yaz    = 1'b0;
    bellek_satir  = '0;
    bellek_veri   = '0;
    if (durum_q == OKU && sayac_q == '0) begin
      oku_gecerli_d = 1'b1;
      oku_adres_d   = {satir_q, {SATIR_OFSET_BIT{1'b0}}};
      if (satir_q < SATIR_SINIR) begin
        oku_veri_d = bellek_q[satir_q[SATIR_BIT-1:0]];
      end else begin
        oku_veri_d = '0;
        hata_d     = 1'b1;
      end
    end
    // The memory line is written on the accepting edge; YAZ only models the busy time.
    if (kabul_gecerli && kabul.yaz) begin
      if (kabul_satir < SATIR_SINIR) begin
        bellek_yaz   = 1'b1;
        bellek_satir = kabul_satir[SATIR_BIT-1:0];
        bellek_veri  = kabul.veri;
      end else begin
        hata_d = 1'b1;
      end
    end else if (yukle_yaz) begin
      bellek_yaz   = 1'b1;
      bellek_satir = yukle_satir[SATIR_BIT-1:0];
      bellek_veri  = yukle_veri_g;
    end
    mesgul_d = (durum_d != BOSTA) || kutu_yukle || (kutu_dolu && !kutu_cek);
  end

  always_ff @(posedge clk_g or negedge resetn) begin
    if (!resetn) begin
      durum_q       <= BOSTA;
      sayac_q       <= '0;
      satir_q       <= '0;
      oku_veri_q    <= '0;
      oku_adres_q   <= '0;
      oku_gecerli_q <= 1'b0;
      mesgul_q      <= 1'b0;
      hata_q        <= 1'b0;
    end else begin
      durum_q       <= durum_d;
      sayac_q       <= sayac_d;
      satir_q       <= satir_d;
      oku_veri_q    <= oku_veri_d;
      oku_adres_q   <= oku_adres_d;
      oku_gecerli_q <= oku_gecerli_d;
      mesgul_q      <= mesgul_d;
      hata_q        <= hata_d;
    end
  end

  // Storage is deliberately not reset so preloaded contents survive a reset.
  always_ff @(posedge clk_g) begin
    if (bellek_yaz) begin
      bellek_q[bellek_satir] <= bellek_veri;
    end
  end

  assign ram_oku_veri_c    = oku_veri_q;
  assign ram_oku_adres_c   = oku_adres_q;
  assign ram_oku_gecerli_c = oku_gecerli_q;
  assign ram_mesgul_c      = mesgul_q;
  assign hata_c            = hata_q;

endmodule

// File: doc/bellek_arabirimi.md
Name: bellek_arabirimi

Overview:
- Line-organised RAM front-end directly downstream of the matrix multiplier; serves its `ram_*` read and write requests.
- Holds SATIR_SAYISI lines of VO_VERI_BIT bits. Addresses are bit addresses; line index is `adres[ADRES_BIT-1:7]`, so each line is 128 bits.
- Models a fixed read/write latency, reports busy, and buffers one request that arrives while an earlier one is in service.
- Also provides a host load/dump path so matrices can be preloaded and results read back.

Parameters:
- ADRES_BIT, 32, address width (shared constant).
- VO_VERI_BIT, 128, line width in bits (shared constant).
- SATIR_SAYISI, 64, number of lines stored.
- OKU_GECIKME, 3, cycles from read acceptance to read-valid pulse (must be ≥1).
- YAZ_GECIKME, 2, cycles a write keeps the block busy (must be ≥1).

Ports:
- clk_g  in  1  clock
- resetn  in  1  asynchronous active-low reset
- ram_adres_g  in  ADRES_BIT  request bit address from the multiplier
- ram_oku_gecerli_g  in  1  read request pulse
- ram_yaz_gecerli_g  in  1  write request pulse
- ram_yaz_veri_g  in  VO_VERI_BIT  write line data
- ram_oku_veri_c  out  VO_VERI_BIT  read line data
- ram_oku_adres_c  out  ADRES_BIT  line-aligned address of the returned line (low 7 bits zero)
- ram_oku_gecerli_c  out  1  one-cycle read-valid pulse
- ram_mesgul_c  out  1  busy
- hata_c  out  1  one-cycle error pulse
- yukle_gecerli_g  in  1  host line write
- yukle_adres_g  in  ADRES_BIT  host bit address
- yukle_veri_g  in  VO_VERI_BIT  host data

Behaviour:
- Reset (async assert, sync deassert):
  - state = BOSTA, pending slot empty, counters 0.
  - All outputs 0.
  - Memory contents are not cleared.
- Request capture: a request is read-pulse or write-pulse sampled at a rising edge.
  - If both are high, the write is accepted first and the read goes to the pending slot. If the slot is full, the read is dropped and hata_c pulses.
- States:
  - BOSTA:
    - Pending slot full → serve it (slot empties).
    - Else write request → YAZ.
    - Else read request → OKU.
    - Else yukle_gecerli_g → write the line in the same cycle, stay in BOSTA.
  - OKU: counter runs from OKU_GECIKME-1 down to 0. At 0:
    - drive ram_oku_veri_c = mem[line], ram_oku_adres_c = `{line, 7'b0}`, ram_oku_gecerli_c = 1 for exactly one cycle;
    - return to BOSTA.
    - Total latency from the accepting edge to the valid cycle is OKU_GECIKME cycles.
  - YAZ: the memory line is written on the accepting edge. The block stays busy for YAZ_GECIKME cycles, then → BOSTA. A read of that line issued afterwards returns the new data.
- ram_mesgul_c = (state != BOSTA) OR pending slot full. It is registered and rises the cycle after acceptance.
- Requests arriving while busy:
  - Stored in the one-entry pending slot (address, kind, data) if it is empty.
  - Otherwise dropped and hata_c pulses.
- Out-of-range line index (≥ SATIR_SAYISI):
  - Read: completes with data 0 and the valid pulse, and hata_c pulses in the same cycle as the valid.
  - Write: no memory change, and hata_c pulses.
- yukle_gecerli_g outside BOSTA, or while a multiplier request is present: ignored, and hata_c pulses.
- ram_oku_veri_c and ram_oku_adres_c hold their last values between valid pulses.
- Reset mid-operation: the in-flight read never returns and the pending slot is discarded.

Decomposition:
- Shared package holds ADRES_BIT, VO_VERI_BIT, line-offset width (7), and the state encoding (BOSTA, OKU, YAZ).
- One sub-module, `bekleyen_istek_kutusu`: the one-entry pending-request slot with full flag, load, and pop.

Test Plan:
1. Host loads line 2 (address 0x100) = 128'h0123…CDEF. Multiplier reads address 0x120 → exactly 3 cycles later: valid = 1 for one cycle, data = 128'h0123…CDEF, ram_oku_adres_c = 0x100.
2. Write 128'hAA..AA to address 0x80. Busy is high for 2 cycles. A following read of address 0x80 → returns 128'hAA..AA.
3. Read of 0x000 accepted, then a second read of 0x080 one cycle later while busy → both return in order, each with its own address. hata_c stays 0.
4. While a read is in flight and the slot holds a request, a third request arrives → it is dropped and hata_c pulses once. The two earlier requests still complete.
5. Read of address 64×128 (line 64, out of range) → data 0, valid pulses, and hata_c pulses in the same cycle.
6. resetn driven low during OKU → all outputs 0 immediately, no valid pulse afterwards. Memory still holds the line-2 value from scenario 1.
